// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment value path: digit
// geometry, the formatter FSM state type and the glyph codes the display
// driver understands besides 0..9.
package seg_pkg;

    localparam int SEG_DIGITS = 6;
    localparam int BCD_W      = 24;
    localparam int MAG_W      = 20;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Non-numeric glyphs; the driver maps these to a minus bar and a dark digit.
    localparam logic [3:0] DIG_MINUS = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd11;

    // A BCD digit at 5 or above would leave the 0..9 range after doubling.
    function automatic logic nibble_needs_add3(input logic [3:0] digit);
        return digit >= 4'd5;
    endfunction

endpackage

// File: rtl/bcd_add3_stage.sv
// Combinational correction step of the shift-add-3 binary-to-BCD algorithm:
// every packed digit that is 5 or more gets 3 added so that the following
// left shift carries correctly into the next decimal digit.
module bcd_add3_stage
    import seg_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [BCD_W-1:0] bcd_o
);

    // Apply the +3 correction independently to each nibble.
    always_comb begin
        // NOTE: bcd_o gets a full default first so no path leaves it unassigned,
        // which keeps this block purely combinational instead of inferring latches.
        bcd_o = bcd_i;
        for (int n = 0; n < BCD_W / 4; n++) begin
            if (nibble_needs_add3(bcd_i[4*n +: 4])) begin
                bcd_o[4*n +: 4] = bcd_i[4*n +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/seg_value_fmt.sv
// Front end for the six-digit 7-segment driver. Takes a signed value over a
// valid/ready handshake, saturates its magnitude, converts it to packed BCD
// with an iterative shift-add-3 engine, and then presents a stable display set
// together with a one-cycle out_valid pulse.
module seg_value_fmt
    import seg_pkg::*;
#(
    parameter int IN_W    = 21,
    parameter int DP_POS  = 0,
    parameter int MAX_MAG = 999999
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [MAG_W-1:0]      disp_data,
    output logic                  disp_sign,
    output logic [SEG_DIGITS-1:0] disp_point,
    output logic                  disp_en,
    output logic [BCD_W-1:0]      bcd,
    output logic                  ovf,
    output logic                  out_valid
);

    // Parameter legality is settled at elaboration; a bad instance never builds.
    if (IN_W < MAG_W + 1 || IN_W > 32) begin : g_bad_in_w
        $error("seg_value_fmt: IN_W must be within 21..32");
    end
    if (DP_POS < 0 || DP_POS >= SEG_DIGITS) begin : g_bad_dp_pos
        $error("seg_value_fmt: DP_POS must be within 0..5");
    end
    if (MAX_MAG < 0 || MAX_MAG > 999999) begin : g_bad_max_mag
        $error("seg_value_fmt: MAX_MAG must fit in six decimal digits");
    end

    localparam logic [IN_W:0]           MAX_MAG_EXT = (IN_W + 1)'(MAX_MAG);
    localparam logic [MAG_W-1:0]        MAX_MAG_M   = MAG_W'(MAX_MAG);
    localparam logic [CNT_W-1:0]        LAST_SHIFT  = CNT_W'(MAG_W - 1);
    // Digit 0 never carries a point, so DP_POS == 0 means "no point".
    localparam logic [SEG_DIGITS-1:0]   DP_ONEHOT   =
        (DP_POS == 0) ? '0 : (SEG_DIGITS'(1) << DP_POS);

    // Control state
    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;

    // Captured operand and conversion engine
    logic               sign_q, sign_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic               ovf_nxt_q, ovf_nxt_d;
    logic [MAG_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   bcd_acc_q, bcd_acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Presented outputs; only written in DONE so they never glitch mid-conversion
    logic [MAG_W-1:0]       disp_data_q, disp_data_d;
    logic                   disp_sign_q, disp_sign_d;
    logic [SEG_DIGITS-1:0]  disp_point_q, disp_point_d;
    logic                   disp_en_q, disp_en_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   ovf_q, ovf_d;
    logic                   out_valid_q, out_valid_d;

    // Magnitude path, one bit wider than the input so |most-negative| fits
    logic [IN_W:0]          in_ext;
    logic [IN_W:0]          mag_full;
    logic                   mag_sat;
    logic [MAG_W-1:0]       mag_cap;

    // Shift-add-3 datapath
    logic [BCD_W-1:0]       bcd_fix;
    logic [BCD_W+MAG_W-1:0] shifted;

    logic                   accept;

    assign in_ext   = {in_data[IN_W-1], in_data};
    assign mag_full = in_data[IN_W-1] ? (~in_ext + 1'b1) : in_ext;
    // Compare at full width before dropping the upper bits.
    assign mag_sat  = mag_full > MAX_MAG_EXT;
    assign mag_cap  = mag_sat ? MAX_MAG_M : mag_full[MAG_W-1:0];

    assign accept   = in_valid && in_ready_q;

    bcd_add3_stage u_add3 (
        .bcd_i (bcd_acc_q),
        .bcd_o (bcd_fix)
    );

    assign shifted = {bcd_fix, shreg_q} << 1;

    // Next-state logic: capture in IDLE, one correct-and-shift per CONV cycle,
    // publish the result in DONE.
    always_comb begin
        state_d      = state_q;
        sign_d       = sign_q;
        mag_d        = mag_q;
        ovf_nxt_d    = ovf_nxt_q;
        shreg_d      = shreg_q;
        bcd_acc_d    = bcd_acc_q;
        cnt_d        = cnt_q;
        disp_data_d  = disp_data_q;
        disp_sign_d  = disp_sign_q;
        disp_point_d = disp_point_q;
        disp_en_d    = disp_en_q;
        bcd_d        = bcd_q;
        ovf_d        = ovf_q;
        out_valid_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sign_d    = in_data[IN_W-1];
                    mag_d     = mag_cap;
                    ovf_nxt_d = mag_sat;
                    shreg_d   = mag_cap;
                    bcd_acc_d = '0;
                    cnt_d     = '0;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                {bcd_acc_d, shreg_d} = shifted;
                cnt_d                = cnt_q + 5'd1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                disp_data_d  = mag_q;
                disp_sign_d  = sign_q && (mag_q != '0);
                disp_point_d = DP_ONEHOT;
                disp_en_d    = 1'b1;
                bcd_d        = bcd_acc_q;
                ovf_d        = ovf_nxt_q;
                out_valid_d  = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Ready is registered so it is low throughout reset and rises on the
        // first clock after it.
        in_ready_d = (state_d == S_IDLE);
    end

    // State registers with synchronous reset; a reset mid-conversion drops the
    // partial result and clears everything the driver sees.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state is written with non-blocking assignments only,
        // so every register samples the pre-edge values regardless of order.
        if (sys_rst) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            sign_q       <= 1'b0;
            mag_q        <= '0;
            ovf_nxt_q    <= 1'b0;
            shreg_q      <= '0;
            bcd_acc_q    <= '0;
            cnt_q        <= '0;
            disp_data_q  <= '0;
            disp_sign_q  <= 1'b0;
            disp_point_q <= '0;
            disp_en_q    <= 1'b0;
            bcd_q        <= '0;
            ovf_q        <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            sign_q       <= sign_d;
            mag_q        <= mag_d;
            ovf_nxt_q    <= ovf_nxt_d;
            shreg_q      <= shreg_d;
            bcd_acc_q    <= bcd_acc_d;
            cnt_q        <= cnt_d;
            disp_data_q  <= disp_data_d;
            disp_sign_q  <= disp_sign_d;
            disp_point_q <= disp_point_d;
            disp_en_q    <= disp_en_d;
            bcd_q        <= bcd_d;
            ovf_q        <= ovf_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign disp_data  = disp_data_q;
    assign disp_sign  = disp_sign_q;
    assign disp_point = disp_point_q;
    assign disp_en    = disp_en_q;
    assign bcd        = bcd_q;
    assign ovf        = ovf_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_seg_value_fmt.sv
// Self-checking bench for seg_value_fmt: directed boundary values plus
// randomized signed inputs, compared against a decimal-arithmetic model.
module tb_seg_value_fmt;

    localparam int IN_W   = 21;
    localparam int TB_DP  = 3;
    localparam int LAT    = 22;
    localparam int BUDGET = 60;

    logic              sys_clk;
    logic              sys_rst;
    logic [IN_W-1:0]   in_data;
    logic              in_valid;
    logic              in_ready;
    logic [19:0]       disp_data;
    logic              disp_sign;
    logic [5:0]        disp_point;
    logic              disp_en;
    logic [23:0]       bcd;
    logic              ovf;
    logic              out_valid;

    logic [52:0]       obs;

    int checks = 0;
    int errors = 0;

    seg_value_fmt #(
        .IN_W    (IN_W),
        .DP_POS  (TB_DP),
        .MAX_MAG (999999)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .disp_data  (disp_data),
        .disp_sign  (disp_sign),
        .disp_point (disp_point),
        .disp_en    (disp_en),
        .bcd        (bcd),
        .ovf        (ovf),
        .out_valid  (out_valid)
    );

    assign obs = {disp_data, disp_sign, disp_point, disp_en, bcd, ovf};

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    initial begin
        #(20 * 20000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the absolute value.
    function automatic logic [23:0] ref_bcd(input longint m);
        logic [23:0] r;
        longint      t;
        r = '0;
        t = m;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check_result(input string tag, input int v);
        longint m;
        logic   sat;
        m   = (v < 0) ? -longint'(v) : longint'(v);
        sat = (m > 999999);
        if (sat) m = 999999;
        check({tag, "_bcd"},   bcd,        ref_bcd(m));
        check({tag, "_mag"},   disp_data,  32'(m));
        check({tag, "_sign"},  disp_sign,  (v < 0) ? 1 : 0);
        check({tag, "_ovf"},   ovf,        sat);
        check({tag, "_point"}, disp_point, 32'(1) << TB_DP);
        check({tag, "_en"},    disp_en,    1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", in_ready, 1);
    endtask

    // Count negedges from the drive negedge until out_valid, while checking
    // that the presented outputs do not move before the pulse.
    task automatic wait_result(input string tag, input logic [52:0] snap, input int start);
        int   lat;
        logic bad;
        lat = start;
        bad = 1'b0;
        while (out_valid !== 1'b1 && lat < BUDGET) begin
            if (obs !== snap) bad = 1'b1;
            @(negedge sys_clk);
            in_valid = (tag == "b2b_a") ? in_valid : 1'b0;
            lat++;
        end
        check({tag, "_lat"},  lat, LAT);
        check({tag, "_hold"}, bad, 0);
    endtask

    task automatic convert(input int v, input string tag);
        logic [52:0] snap;
        wait_ready();
        snap     = obs;
        in_data  = v[IN_W-1:0];
        in_valid = 1'b1;
        @(negedge sys_clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, in_ready, 0);
        wait_result(tag, snap, 1);
        check_result(tag, v);
        @(negedge sys_clk);
        check({tag, "_pulse"}, out_valid, 0);
    endtask

    initial begin
        logic        seen;
        logic [52:0] snap;
        int          a;
        int          b;
        int          dir [10];

        sys_rst  = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // 1: reset and idle
        repeat (3) @(negedge sys_clk);
        check("rst_ready_low", in_ready, 0);
        sys_rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge sys_clk);
            if (out_valid) seen = 1'b1;
        end
        check("idle_ready", in_ready, 1);
        check("idle_no_valid", seen, 0);
        check("idle_en", disp_en, 0);
        check("idle_data", disp_data, 0);
        check("idle_bcd", bcd, 0);
        check("idle_flags", {disp_sign, disp_point, ovf}, 0);

        // 2-4: directed values and boundaries
        dir = '{12345, -907, 0, 1000000, -1048576, -1, 999999, -999999, -1000000, 1048575};
        foreach (dir[i]) convert(dir[i], $sformatf("dir%0d", i));

        // Randomized values across the full input range and the unsaturated range
        for (int i = 0; i < 10; i++) begin
            int v;
            if (i % 2 == 1) v = int'($urandom_range(2097151, 0)) - 1048576;
            else            v = int'($urandom_range(1999998, 0)) - 999999;
            convert(v, $sformatf("rnd%0d", i));
        end

        // 5: valid held during CONV; next value taken only once idle again
        a = 654321;
        b = -77;
        wait_ready();
        snap     = obs;
        in_data  = a[IN_W-1:0];
        in_valid = 1'b1;
        @(negedge sys_clk);
        check("b2b_busy", in_ready, 0);
        in_data = b[IN_W-1:0];
        wait_result("b2b_a", snap, 1);
        check_result("b2b_a", a);
        snap = obs;
        @(negedge sys_clk);
        in_valid = 1'b0;
        wait_result("b2b_b", snap, 1);
        check_result("b2b_b", b);
        @(negedge sys_clk);

        // 6: reset ten cycles into a conversion
        wait_ready();
        in_data  = 21'd555555;
        in_valid = 1'b1;
        @(negedge sys_clk);
        in_valid = 1'b0;
        repeat (9) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_ready", in_ready, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge sys_clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", seen, 0);
        check("midrst_en", disp_en, 0);
        check("midrst_data", disp_data, 0);
        check("midrst_bcd", bcd, 0);
        check("midrst_flags", {disp_sign, disp_point, ovf}, 0);
        convert(42, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_value_fmt.md
Name: seg_value_fmt

Overview:
- Upstream feeder for the six-digit dynamic 7-segment driver.
- Accepts a signed two's-complement result through a valid/ready handshake (e.g. classifier score or latency counter), saturates it to the displayable range, and converts it to packed BCD with an iterative shift-add-3 engine.
- Holds a stable magnitude/sign/point/enable set for the display driver, plus the BCD digits for other consumers.

Parameters:
- IN_W, 21, input width incl. sign bit; range 21..32.
- DP_POS, 0, decimal-point digit index 0..5 (0 = no point shown); sets one-hot point output.
- MAX_MAG, 999999, saturation limit on magnitude.

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst  in  1  synchronous reset, active-high
- in_data  in  IN_W  signed value to display
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept (high only in IDLE)
- disp_data  out  20  saturated magnitude, binary
- disp_sign  out  1  1 = negative, show minus
- disp_point  out  6  one-hot decimal point, active-high
- disp_en  out  1  display enable
- bcd  out  24  six packed BCD digits, [3:0] = units
- ovf  out  1  last accepted value was saturated
- out_valid  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset values:
  - in_ready=0 during reset, 1 on first cycle after.
  - disp_data=0, disp_sign=0, disp_point=0, disp_en=0, bcd=0, ovf=0, out_valid=0.
- FSM has three states:
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready, capture sign = in_data[IN_W-1].
    - Capture mag = |in_data|, computed in IN_W+1 bits so the most-negative input is correct.
    - If mag>MAX_MAG: mag=MAX_MAG, ovf_nxt=1.
    - Load a 20-bit shift register with mag; clear 24-bit BCD accumulator and 5-bit bit counter. Go to CONV.
  - CONV: each cycle:
    - Every BCD nibble >=5 gets +3.
    - Then shift {bcd_acc, shreg} left by 1.
    - Counter increments; after 20 shifts go to DONE.
  - DONE:
    - Register outputs: disp_data=mag, bcd=bcd_acc, ovf=ovf_nxt.
    - disp_sign = sign && (mag!=0); negative zero is not possible from two's complement, but the guard is still required.
    - disp_point = (DP_POS==0) ? 0 : 1<<DP_POS.
    - disp_en=1 (stays 1 until reset). out_valid=1 for this cycle. Return to IDLE.
- Latency and throughput:
  - Accept edge to out_valid is 22 cycles (1 load, 20 shift, 1 done); in_ready low for 21 cycles.
  - Throughput is one conversion per 22 cycles.
- Hold: all disp_*/bcd/ovf outputs stay constant between out_valid pulses; no glitching during CONV.
- Handshake:
  - in_valid while not ready is ignored; the source must hold data.
  - in_valid in the same cycle as DONE is not accepted; it is accepted on the next IDLE cycle.
- Boundaries:
  - in_data=0 gives bcd=0, sign=0.
  - in_data=-1 gives bcd=000001, sign=1.
  - Values ±999999 pass through unsaturated.
  - ±1000000 or beyond saturates to 999999 with ovf=1 and sign preserved.
  - Most-negative input (e.g. -2^20 for IN_W=21) saturates, sign=1.
- Reset mid-CONV: conversion is aborted, state=IDLE, all outputs return to reset values, and the partial result is never presented.
- Width rules:
  - IN_W<21 is illegal; elaboration-time check.
  - Magnitude compare is done at IN_W+1 bits before truncation to 20.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_DIGITS=6, BCD_W=24, MAG_W=20.
  - FSM state enum {S_IDLE,S_CONV,S_DONE}.
  - Glyph codes DIG_MINUS=4'd10, DIG_BLANK=4'd11, shared with the display driver.
- One natural sub-module: bcd_add3_stage, combinational per-nibble ">=5 then +3" over 24 bits. Reusable by other converters.

Test Plan:
1. Reset, then idle 10 cycles -> in_ready=1, disp_en=0, all outputs 0, no out_valid.
2. Send in_data=12345, pulse valid -> out_valid exactly 22 cycles after accept, bcd=24'h012345, disp_data=12345, sign=0, ovf=0, disp_en=1.
3. Send in_data=-907 -> bcd=24'h000907, disp_data=907, disp_sign=1. Then send 0 -> bcd=0, sign=0.
4. Send 1000000, then -1048576 -> both give bcd=24'h999999, disp_data=999999, ovf=1; signs 0 and 1.
5. Hold in_valid high with a new value during CONV -> in_ready=0, value not taken until IDLE; outputs unchanged until the next out_valid. Back-to-back values are accepted 22 cycles apart.
6. Assert sys_rst 10 cycles into a conversion of 555555 -> no out_valid; all outputs reset; next value 42 converts correctly to 24'h000042.
